// File: rtl/exec_pkg.sv
// exec_pkg: the constants, types and ALU helper shared by the execute/writeback stage.
//   DATA_W / REG_AW : operand/result width and register index width
//   MUL_ITERS       : shift-add iterations for a full 16-bit multiply
//   op_t            : opcode encoding
//   state_t         : stage FSM states
//   alu_eval()      : single-cycle ALU result plus carry/no-borrow
package exec_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_AW    = 2;
  localparam int MUL_ITERS = 16;
  localparam int CNT_W     = 5;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carry;
  } alu_out_t;

  // Single-cycle ALU. Carry is the adder carry-out for ADD and the
  // no-borrow flag for SUB (computed as a + ~b + 1); zero for every other op.
  function automatic alu_out_t alu_eval(input op_t op,
                                        input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
    alu_out_t          r;
    logic [DATA_W:0]   wide;
    r    = '0;
    wide = '0;
    case (op)
      OP_ADD: begin
        wide     = {1'b0, a} + {1'b0, b};
        r.result = wide[DATA_W-1:0];
        r.carry  = wide[DATA_W];
      end
      OP_SUB: begin
        wide     = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
        r.result = wide[DATA_W-1:0];
        r.carry  = wide[DATA_W];
      end
      OP_AND: r.result = a & b;
      OP_OR:  r.result = a | b;
      OP_SLT: r.result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: r.result = a << b[3:0];
      OP_SRL: r.result = a >> b[3:0];
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: iterative 16x16 shift-add multiplier, low 16 bits of product.
// Only compiled when EXEC_MULT_EN is defined; without it the stage has no multiplier.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   start          : load operands and clear accumulator/counter (one cycle)
//   multiplicand   : operand A
//   multiplier     : operand B
//   done           : high during the cycle whose edge performs the last iteration
//   product        : low 16 bits of the product, valid while done is high
`ifdef EXEC_MULT_EN
module shift_add_multiplier
  import exec_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] multiplicand,
  input  logic [DATA_W-1:0] multiplier,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic [DATA_W-1:0] mcand_r;
  logic [DATA_W-1:0] mplier_r;
  logic [DATA_W-1:0] acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              active_r;
  logic [DATA_W-1:0] addend_s;
  logic [DATA_W-1:0] acc_nx_s;
  logic              last_s;

  // One iteration's partial sum; product is exposed from the next-value path so
  // the final iteration's result is available to be registered on the same edge.
  always_comb begin
    addend_s = mplier_r[0] ? mcand_r : '0;
    acc_nx_s = acc_r + addend_s;
    last_s   = active_r && (cnt_r == CNT_W'(MUL_ITERS - 1));
    done     = last_s;
    product  = acc_nx_s;
  end

  // Operand shift registers, accumulator and iteration counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      active_r <= 1'b0;
    end else if (start) begin
      mcand_r  <= multiplicand;
      mplier_r <= multiplier;
      acc_r    <= '0;
      cnt_r    <= '0;
      active_r <= 1'b1;
    end else if (active_r) begin
      acc_r    <= acc_nx_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CNT_W'(1);
      if (last_s) begin
        active_r <= 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/execute_writeback.sv
// execute_writeback: execute + writeback stage feeding a 4x16 register file.
// Single-cycle ALU ops go IDLE -> WB; MUL (when EXEC_MULT_EN is defined) goes
// IDLE -> MUL (16 iterations) -> WB. WB drives a one-cycle RegWrite pulse.
// Build option: EXEC_MULT_EN. When undefined, opcode 111 is reported via a
// one-cycle Illegal pulse and nothing is written.
// Ports:
//   Clock, Reset        : rising-edge clock, asynchronous active-high reset
//   InValid / InReady   : upstream handshake, transfer when both high at an edge
//   Op, ReadRS, ReadRT  : opcode and operands
//   RDIn                : destination register index
//   WD, RD, RegWrite    : register file write port
//   Zero, Carry         : status of the last completed write
//   Illegal             : one-cycle pulse for an unsupported opcode
//   Busy                : stage is not in IDLE
module execute_writeback
  import exec_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [2:0]        Op,
  input  logic [DATA_W-1:0] ReadRS,
  input  logic [DATA_W-1:0] ReadRT,
  input  logic [REG_AW-1:0] RDIn,
  output logic [DATA_W-1:0] WD,
  output logic [REG_AW-1:0] RD,
  output logic              RegWrite,
  output logic              Zero,
  output logic              Carry,
  output logic              Illegal,
  output logic              Busy
);

  state_t            state_r;
  state_t            state_nx_s;
  op_t               op_s;
  alu_out_t          alu_s;
  logic              accept_s;
  logic              is_mul_s;

  logic [DATA_W-1:0] wd_r;
  logic [REG_AW-1:0] rd_r;
  logic              reg_write_r;
  logic              zero_r;
  logic              carry_r;

`ifdef EXEC_MULT_EN
  logic [REG_AW-1:0] rd_lat_r;
  logic              mul_start_s;
  logic              mul_done_s;
  logic [DATA_W-1:0] mul_product_s;
`else
  logic              illegal_r;
`endif

  // Handshake and ALU evaluation on the live inputs; the accept edge registers them.
  always_comb begin
    op_s     = op_t'(Op);
    alu_s    = alu_eval(op_s, ReadRS, ReadRT);
    is_mul_s = (op_s == OP_MUL);
    accept_s = InValid && InReady;
  end

  assign InReady  = (state_r == IDLE) && !Reset;
  assign Busy     = (state_r != IDLE);
  assign WD       = wd_r;
  assign RD       = rd_r;
  assign RegWrite = reg_write_r;
  assign Zero     = zero_r;
  assign Carry    = carry_r;

`ifdef EXEC_MULT_EN
  assign Illegal     = 1'b0;
  assign mul_start_s = accept_s && is_mul_s;

  shift_add_multiplier u_mult (
    .clock        (Clock),
    .reset        (Reset),
    .start        (mul_start_s),
    .multiplicand (ReadRS),
    .multiplier   (ReadRT),
    .done         (mul_done_s),
    .product      (mul_product_s)
  );
`else
  assign Illegal = illegal_r;
`endif

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
`ifdef EXEC_MULT_EN
          if (is_mul_s) begin
            state_nx_s = MUL;
          end else begin
            state_nx_s = WB;
          end
`else
          state_nx_s = WB;
`endif
        end else begin
          state_nx_s = IDLE;
        end
      end
`ifdef EXEC_MULT_EN
      MUL: begin
        if (mul_done_s) begin
          state_nx_s = WB;
        end else begin
          state_nx_s = MUL;
        end
      end
`endif
      WB:      state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Writeback registers: loaded when the result becomes known, so they are
  // valid for the whole WB cycle and hold their value afterwards.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wd_r        <= '0;
      rd_r        <= '0;
      reg_write_r <= 1'b0;
      zero_r      <= 1'b0;
      carry_r     <= 1'b0;
`ifdef EXEC_MULT_EN
      rd_lat_r    <= '0;
`else
      illegal_r   <= 1'b0;
`endif
    end else begin
      reg_write_r <= 1'b0;
`ifndef EXEC_MULT_EN
      illegal_r   <= 1'b0;
`endif
      if (accept_s) begin
        if (is_mul_s) begin
`ifdef EXEC_MULT_EN
          rd_lat_r  <= RDIn;
`else
          // No multiplier: flag the op, leave WD/RD/Zero/Carry untouched.
          illegal_r <= 1'b1;
`endif
        end else begin
          wd_r        <= alu_s.result;
          rd_r        <= RDIn;
          reg_write_r <= 1'b1;
          zero_r      <= (alu_s.result == '0);
          carry_r     <= alu_s.carry;
        end
      end
`ifdef EXEC_MULT_EN
      else if ((state_r == MUL) && mul_done_s) begin
        wd_r        <= mul_product_s;
        rd_r        <= rd_lat_r;
        reg_write_r <= 1'b1;
        zero_r      <= (mul_product_s == '0);
        carry_r     <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_execute_writeback.sv
// tb_execute_writeback: randomized + directed self-checking bench for execute_writeback.
// A transaction-level model predicts, per clock edge, when each accepted op is
// written back and what the held write-port/status values must be.
module tb_execute_writeback;

`ifdef EXEC_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [2:0]  Op = 3'd0;
  logic [15:0] ReadRS = 16'd0;
  logic [15:0] ReadRT = 16'd0;
  logic [1:0]  RDIn = 2'd0;
  logic [15:0] WD;
  logic [1:0]  RD;
  logic        RegWrite, Zero, Carry, Illegal, Busy;

  execute_writeback dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Op(Op), .ReadRS(ReadRS), .ReadRT(ReadRT), .RDIn(RDIn),
    .WD(WD), .RD(RD), .RegWrite(RegWrite), .Zero(Zero), .Carry(Carry),
    .Illegal(Illegal), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;
  int edge_no = 0;
  int exp_writes = 0;
  int obs_writes = 0;

  // model state
  bit          pend = 1'b0;
  int          p_wb = 0;
  bit          p_ill = 1'b0;
  logic [15:0] p_wd;
  logic [1:0]  p_rd;
  logic        p_carry;
  logic [15:0] e_wd = 16'd0;
  logic [1:0]  e_rd = 2'd0;
  logic        e_zero = 1'b0, e_carry = 1'b0;
  logic        exp_rw = 1'b0, exp_ill = 1'b0, exp_busy = 1'b0, exp_ready = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, req, edge_no);
    end
  endtask

  // Reference arithmetic straight from the opcode definitions.
  function automatic void predict(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic c);
    logic [31:0] s;
    r = 16'd0; c = 1'b0;
    case (op)
      3'd0: begin s = 32'(a) + 32'(b); r = s[15:0]; c = s[16]; end
      3'd1: begin r = a - b; c = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
      3'd5: r = a << b[3:0];
      3'd6: r = a >> b[3:0];
      default: begin s = 32'(a) * 32'(b); r = s[15:0]; end
    endcase
  endfunction

  task automatic model_reset();
    pend = 1'b0; e_wd = 16'd0; e_rd = 2'd0; e_zero = 1'b0; e_carry = 1'b0;
    exp_rw = 1'b0; exp_ill = 1'b0; exp_busy = 1'b0; exp_ready = 1'b1;
  endtask

  // Advance the model across one rising edge.
  task automatic model_edge(input bit acc, input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [1:0] rd);
    if (Reset) begin
      model_reset();
      return;
    end
    if (pend && edge_no > p_wb) pend = 1'b0;
    if (acc) begin
      pend  = 1'b1;
      p_ill = (op == 3'd7) && !MULT_EN;
      p_wb  = edge_no + (((op == 3'd7) && MULT_EN) ? 16 : 0);
      predict(op, a, b, p_wd, p_carry);
      p_rd  = rd;
    end
    exp_rw = 1'b0; exp_ill = 1'b0;
    if (pend && edge_no == p_wb) begin
      if (p_ill) exp_ill = 1'b1;
      else begin
        exp_rw = 1'b1; exp_writes++;
        e_wd = p_wd; e_rd = p_rd; e_zero = (p_wd == 16'd0); e_carry = p_carry;
      end
    end
    exp_busy  = pend && (edge_no <= p_wb);
    exp_ready = !exp_busy;
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic compare();
    if (RegWrite === 1'b1) obs_writes++;
    chk("InReady", InReady, exp_ready && !Reset);
    chk("Busy", Busy, exp_busy);
    chk("RegWrite", RegWrite, exp_rw);
    chk("Illegal", Illegal, exp_ill);
    chk("WD", WD, e_wd);
    chk("RD", RD, e_rd);
    chk("Zero", Zero, e_zero);
    chk("Carry", Carry, e_carry);
  endtask

  // Called at a negedge: drive inputs, cross one rising edge, check at the next negedge.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [1:0] rd);
    bit acc;
    InValid = v; Op = op; ReadRS = a; ReadRT = b; RDIn = rd;
    acc = v && exp_ready && !Reset;
    @(posedge Clock);
    edge_no++;
    model_edge(acc, op, a, b, rd);
    @(negedge Clock);
    compare();
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] corner [5];
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000;
    corner[3] = 16'h7FFF; corner[4] = 16'h0001;
    if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
    return 16'($urandom);
  endfunction

  initial begin
    // reset state
    @(negedge Clock);
    compare();
    chk("reset_inready", InReady, 1'b0);
    chk("reset_wd", WD, 16'h0000);
    Reset = 1'b0;
    #1;
    chk("release_inready", InReady, 1'b1);
    @(negedge Clock);
    compare();

    // ADD wraps with carry, write pulse exactly one cycle after accept
    cycle(1'b1, 3'd0, 16'hFFFF, 16'h0001, 2'd2);
    chk("add_rw", RegWrite, 1'b1);
    chk("add_wd", WD, 16'h0000);
    chk("add_rd", RD, 2'd2);
    chk("add_zero", Zero, 1'b1);
    chk("add_carry", Carry, 1'b1);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, 2'd0);
    chk("add_rw_once", RegWrite, 1'b0);

    // SLT signed, SRL uses only ReadRT[3:0]
    cycle(1'b1, 3'd4, 16'h8000, 16'h0001, 2'd1);
    chk("slt_wd", WD, 16'h0001);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, 2'd0);
    cycle(1'b1, 3'd6, 16'h8000, 16'h00F3, 2'd0);
    chk("srl_wd", WD, 16'h1000);
    chk("srl_carry", Carry, 1'b0);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, 2'd0);

    // back-to-back with InValid held high
    cycle(1'b1, 3'd3, 16'h1200, 16'h0034, 2'd3);
    chk("b2b_first_wd", WD, 16'h1234);
    cycle(1'b1, 3'd2, 16'hFF0F, 16'h0FF0, 2'd0);
    chk("b2b_gap_rw", RegWrite, 1'b0);
    chk("b2b_gap_ready", InReady, 1'b1);
    cycle(1'b1, 3'd2, 16'hFF0F, 16'h0FF0, 2'd0);
    chk("b2b_second_rw", RegWrite, 1'b1);
    chk("b2b_second_wd", WD, 16'h0F00);
    chk("b2b_second_rd", RD, 2'd0);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, 2'd0);

`ifdef EXEC_MULT_EN
    // MUL: InReady low for cycles N+1..N+17, write in cycle N+17
    cycle(1'b1, 3'd7, 16'h0123, 16'h0045, 2'd1);
    for (int i = 0; i < 16; i++) begin
      chk("mul_inready_low", InReady, 1'b0);
      chk("mul_no_early_rw", RegWrite, 1'b0);
      cycle(1'b0, 3'd0, 16'h0, 16'h0, 2'd0);
    end
    chk("mul_rw", RegWrite, 1'b1);
    chk("mul_wd", WD, 16'h4E6F);
    chk("mul_inready_wb", InReady, 1'b0);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, 2'd0);
    // start a multiply and abort it at iteration 8
    cycle(1'b1, 3'd7, 16'h00FF, 16'h0101, 2'd2);
    for (int i = 0; i < 8; i++) cycle(1'b0, 3'd0, 16'h0, 16'h0, 2'd0);
`else
    // opcode 111 without multiplier
    cycle(1'b1, 3'd7, 16'h0123, 16'h0045, 2'd1);
    chk("ill_pulse", Illegal, 1'b1);
    chk("ill_rw", RegWrite, 1'b0);
    chk("ill_wd_held", WD, 16'h0F00);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, 2'd0);
    chk("ill_pulse_end", Illegal, 1'b0);
    // abort an op in flight
    cycle(1'b1, 3'd1, 16'h0005, 16'h0003, 2'd2);
`endif
    chk("pre_reset_busy", Busy, 1'b1);
    #2 Reset = 1'b1;
    model_reset();
    #1;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_rw", RegWrite, 1'b0);
    chk("rst_inready", InReady, 1'b0);
    chk("rst_wd", WD, 16'h0000);
    @(negedge Clock);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, 2'd0);
    cycle(1'b0, 3'd0, 16'h0, 16'h0, 2'd0);
    Reset = 1'b0;
    #1;
    chk("rst_release_ready", InReady, 1'b1);
    @(negedge Clock);
    compare();
    cycle(1'b1, 3'd0, 16'h0010, 16'h0020, 2'd3);
    chk("post_rst_wd", WD, 16'h0030);
    chk("post_rst_rw", RegWrite, 1'b1);
    chk("post_rst_rd", RD, 2'd3);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(9) < 7), 3'($urandom_range(7)), pick(), pick(), 2'($urandom_range(3)));
    end
    // drain
    for (int i = 0; i < 20; i++) cycle(1'b0, 3'd0, 16'h0, 16'h0, 2'd0);
    chk("write_count", obs_writes, exp_writes);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
